mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline. Holds the EX/MEM pipeline register loaded from the execute stage (ALU result, store data, destination register from the RegDst mux), runs loads and stores against an external word memory through a req/ack handshake, and loads the MEM/WB register for write-back. Also drives the MEM-stage forwarding value and register back to execute, and stalls upstream while a memory access is outstanding.

---
 rtl/mem_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage MIPS pipeline.
//
// Holds the EX/MEM pipeline register, runs loads and stores against an external
// word memory through a req/ack handshake, and loads the MEM/WB register.
// The EX/MEM contents are forwarded back to execute, and upstream is stalled
// while a memory access waits for its acknowledge.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   in_valid, alu_result, store_data,
//   dest_reg, mem_read, mem_write,
//   reg_write, mem_to_reg            instruction from the execute stage
//   stall_o                          upstream must hold and not advance
//   fwd_en, fwd_reg, fwd_value       MEM-stage forwarding path to execute
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata, mem_ack    word-memory handshake
//   wb_valid, wb_reg_write, wb_reg,
//   wb_data                          MEM/WB register towards write-back
//   misalign_o                       pulse: access with alu_result[1:0] != 0
//   bus_err_o                        pulse: access aborted on timeout
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  dest_reg,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    output logic        stall_o,
    output logic        fwd_en,
    output logic [4:0]  fwd_reg,
    output logic [31:0] fwd_value,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    // EX/MEM register
    logic        ex_valid_q;
    logic        ex_load_q;
    logic        ex_store_q;
    logic        ex_reg_write_q;
    logic        ex_mem_to_reg_q;
    logic [31:0] ex_alu_q;
    logic [31:0] ex_sdata_q;
    logic [4:0]  ex_dest_q;

    // MEM/WB register
    logic        wb_valid_q, wb_valid_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic        misalign_q;

    logic        in_load;
    logic        in_store;
    logic        in_mem_op;
    logic        in_access;
    logic        timeout_hit;
    logic        stall;
    logic        load_en;

    // Store wins over load when both control bits are set.
    assign in_store  = in_valid & mem_write;
    assign in_load   = in_valid & ~mem_write & mem_read;
    assign in_mem_op = in_store | in_load;

    assign in_access   = (state_q == StAccess);
    assign timeout_hit = in_access & ~mem_ack & (cnt_q == 8'(TIMEOUT - 1));
    assign stall       = in_access & ~mem_ack & ~timeout_hit;
    assign load_en     = ~stall;

    // ------------------------------------------------------------------
    // Access FSM and timeout counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_mem_op) begin
                    state_d = StAccess;
                    cnt_d   = 8'd0;
                end
            end
            StAccess: begin
                if (stall) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    // A new load/store entering on the completing edge keeps
                    // the request asserted without a gap.
                    state_d = in_mem_op ? StAccess : StIdle;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q      <= 1'b0;
            ex_load_q       <= 1'b0;
            ex_store_q      <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_to_reg_q <= 1'b0;
            ex_alu_q        <= 32'd0;
            ex_sdata_q      <= 32'd0;
            ex_dest_q       <= 5'd0;
        end else if (load_en) begin
            ex_valid_q      <= in_valid;
            ex_load_q       <= in_load;
            ex_store_q      <= in_store;
            ex_reg_write_q  <= in_valid & reg_write & ~mem_write;
            ex_mem_to_reg_q <= in_valid & mem_to_reg;
            ex_alu_q        <= alu_result;
            ex_sdata_q      <= store_data;
            ex_dest_q       <= dest_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= load_en & in_mem_op & (alu_result[1:0] != 2'b00);
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB register: the EX/MEM instruction retires whenever the stage is
    // not stalled, otherwise a bubble is inserted.
    // ------------------------------------------------------------------
    always_comb begin
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
        wb_reg_d       = 5'd0;
        wb_data_d      = 32'd0;
        if (load_en && ex_valid_q) begin
            wb_valid_d     = 1'b1;
            // An aborted access must not update the register file.
            wb_reg_write_d = ex_reg_write_q & (ex_dest_q != 5'd0) & ~timeout_hit;
            wb_reg_d       = ex_dest_q;
            wb_data_d      = (ex_load_q && ex_mem_to_reg_q && in_access && mem_ack)
                             ? mem_rdata : ex_alu_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_reg_q       <= 5'd0;
            wb_data_q      <= 32'd0;
        end else begin
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_reg_q       <= wb_reg_d;
            wb_data_q      <= wb_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall_o   = stall;
    // Loads never forward from here; load-use is resolved by the hazard unit.
    assign fwd_en    = ex_valid_q & ex_reg_write_q & ~ex_mem_to_reg_q & ~ex_load_q
                       & (ex_dest_q != 5'd0);
    assign fwd_reg   = ex_dest_q;
    assign fwd_value = ex_alu_q;

    assign mem_req   = in_access;
    assign mem_we    = in_access & ex_store_q;
    assign mem_addr  = {ex_alu_q[31:2], 2'b00};
    assign mem_wdata = ex_sdata_q;

    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_reg       = wb_reg_q;
    assign wb_data      = wb_data_q;

    assign misalign_o = misalign_q;
    assign bus_err_o  = timeout_hit;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage. Table-driven ALU vectors,
// hand-written handshake sequences, then randomized traffic against a
// transaction-level reference model.
module tb_mem_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] alu_result, store_data;
    logic [4:0]  dest_reg;
    logic        mem_read, mem_write, reg_write, mem_to_reg;
    logic        stall_o, fwd_en;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_value;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        misalign_o, bus_err_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .dest_reg     (dest_reg),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .stall_o      (stall_o),
        .fwd_en       (fwd_en),
        .fwd_reg      (fwd_reg),
        .fwd_value    (fwd_value),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o)
    );

    // kind: 0 = ALU op, 1 = load, 2 = store
    typedef struct packed {
        logic        valid;
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  dest;
        logic        rw;
        logic        m2r;
        logic        rd;
    } instr_t;

    typedef struct packed {
        logic        v;
        logic [31:0] alu;
        logic [4:0]  dest;
        logic        rw;
        logic        exp_fwd;
        logic        exp_wbv;
        logic        exp_wbwe;
    } alu_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] d, input logic rd, input logic wr,
                         input logic rw, input logic m2r);
        in_valid   = v;
        alu_result = a;
        store_data = sd;
        dest_reg   = d;
        mem_read   = rd;
        mem_write  = wr;
        reg_write  = rw;
        mem_to_reg = m2r;
    endtask

    task automatic idle_in();
        drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drive_instr(input instr_t i);
        drive(i.valid, i.addr, i.sdata, i.dest, (i.kind == 2'd1) | ((i.kind == 2'd2) & i.rd),
              i.kind == 2'd2, i.rw, i.m2r);
    endtask

    function automatic instr_t rand_instr();
        instr_t r;
        r.valid = ($urandom_range(0, 4) != 0);
        r.kind  = 2'($urandom_range(0, 2));
        r.addr  = $urandom();
        if (r.kind != 2'd0 && $urandom_range(0, 3) != 0) r.addr[1:0] = 2'b00;
        r.sdata = $urandom();
        r.dest  = 5'($urandom_range(0, 31));
        r.rw    = (r.kind == 2'd1) ? 1'b1 : 1'($urandom_range(0, 1));
        r.m2r   = (r.kind == 2'd1) ? 1'b1 : ((r.kind == 2'd2) ? 1'($urandom_range(0, 1)) : 1'b0);
        r.rd    = (r.kind == 2'd2) ? 1'($urandom_range(0, 1)) : 1'b0;
        return r;
    endfunction

    function automatic int pick_lat();
        int p;
        p = int'($urandom_range(0, 9));
        if (p == 0) return TO + 3;
        if (p == 1) return TO;
        return int'($urandom_range(1, 4));
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_stall"}, stall_o, 0);
        chk({tag, "_fwd_en"}, fwd_en, 0);
        chk({tag, "_fwd_reg"}, fwd_reg, 0);
        chk({tag, "_fwd_value"}, fwd_value, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_wb_reg_write"}, wb_reg_write, 0);
        chk({tag, "_wb_reg"}, wb_reg, 0);
        chk({tag, "_wb_data"}, wb_data, 0);
        chk({tag, "_misalign"}, misalign_o, 0);
        chk({tag, "_bus_err"}, bus_err_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    alu_vec_t tbl [6];

    instr_t   pend, nxt;
    int       wait_c, lat;
    bit       m_stall, is_mem, ack, to;
    bit       e_wbv, e_wbwe, e_mis;
    logic [4:0]  e_wbreg;
    logic [31:0] e_wbdata;

    initial begin
        tbl[0] = '{v: 1'b1, alu: 32'h0000_0007, dest: 5'd5,  rw: 1'b1,
                   exp_fwd: 1'b1, exp_wbv: 1'b1, exp_wbwe: 1'b1};
        tbl[1] = '{v: 1'b1, alu: 32'hFFFF_FFFF, dest: 5'd31, rw: 1'b1,
                   exp_fwd: 1'b1, exp_wbv: 1'b1, exp_wbwe: 1'b1};
        tbl[2] = '{v: 1'b1, alu: 32'h1234_5678, dest: 5'd0,  rw: 1'b1,
                   exp_fwd: 1'b0, exp_wbv: 1'b1, exp_wbwe: 1'b0};
        tbl[3] = '{v: 1'b1, alu: 32'hCAFE_0000, dest: 5'd10, rw: 1'b0,
                   exp_fwd: 1'b0, exp_wbv: 1'b1, exp_wbwe: 1'b0};
        tbl[4] = '{v: 1'b0, alu: 32'h1111_1111, dest: 5'd7,  rw: 1'b1,
                   exp_fwd: 1'b0, exp_wbv: 1'b0, exp_wbwe: 1'b0};
        tbl[5] = '{v: 1'b1, alu: 32'h0000_0003, dest: 5'd1,  rw: 1'b1,
                   exp_fwd: 1'b1, exp_wbv: 1'b1, exp_wbwe: 1'b1};

        reset     = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        idle_in();
        next_edge();
        next_edge();
        #1;
        check_reset_state("reset");
        reset = 1'b0;

        // Table-driven ALU ops; a stray ack while idle must be ignored.
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].v, tbl[i].alu, 32'd0, tbl[i].dest, 1'b0, 1'b0, tbl[i].rw, 1'b0);
            next_edge();
            idle_in();
            mem_ack = 1'b1;
            #1;
            chk($sformatf("tbl%0d_fwd_en", i), fwd_en, tbl[i].exp_fwd);
            if (tbl[i].exp_fwd) begin
                chk($sformatf("tbl%0d_fwd_reg", i), fwd_reg, tbl[i].dest);
                chk($sformatf("tbl%0d_fwd_value", i), fwd_value, tbl[i].alu);
            end
            chk($sformatf("tbl%0d_stall", i), stall_o, 0);
            chk($sformatf("tbl%0d_mem_req", i), mem_req, 0);
            next_edge();
            mem_ack = 1'b0;
            chk($sformatf("tbl%0d_wb_valid", i), wb_valid, tbl[i].exp_wbv);
            chk($sformatf("tbl%0d_wb_reg_write", i), wb_reg_write, tbl[i].exp_wbwe);
            if (tbl[i].exp_wbv) begin
                chk($sformatf("tbl%0d_wb_reg", i), wb_reg, tbl[i].dest);
                chk($sformatf("tbl%0d_wb_data", i), wb_data, tbl[i].alu);
            end
        end

        // LW 0x40 -> r8, acknowledged in the third request cycle.
        drive(1'b1, 32'h40, 32'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
        next_edge();
        idle_in();
        for (int c = 1; c <= 3; c++) begin
            mem_ack   = (c == 3);
            mem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
            #1;
            chk($sformatf("lw_c%0d_mem_req", c), mem_req, 1);
            chk($sformatf("lw_c%0d_stall", c), stall_o, (c < 3) ? 1 : 0);
            chk($sformatf("lw_c%0d_fwd_en", c), fwd_en, 0);
            chk($sformatf("lw_c%0d_mem_addr", c), mem_addr, 32'h40);
            chk($sformatf("lw_c%0d_mem_we", c), mem_we, 0);
            next_edge();
            chk($sformatf("lw_c%0d_wb_valid", c), wb_valid, (c == 3) ? 1 : 0);
        end
        mem_ack = 1'b0;
        #1;
        chk("lw_done_wb_data", wb_data, 32'hDEAD_BEEF);
        chk("lw_done_wb_reg", wb_reg, 8);
        chk("lw_done_wb_reg_write", wb_reg_write, 1);
        chk("lw_done_mem_req", mem_req, 0);

        // SW 0x1234 -> 0x44, ack in the first request cycle; reg_write is ignored.
        drive(1'b1, 32'h44, 32'h1234, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        next_edge();
        idle_in();
        mem_ack = 1'b1;
        #1;
        chk("sw_mem_req", mem_req, 1);
        chk("sw_mem_we", mem_we, 1);
        chk("sw_mem_wdata", mem_wdata, 32'h1234);
        chk("sw_mem_addr", mem_addr, 32'h44);
        chk("sw_stall", stall_o, 0);
        chk("sw_fwd_en", fwd_en, 0);
        next_edge();
        mem_ack = 1'b0;
        #1;
        chk("sw_wb_valid", wb_valid, 1);
        chk("sw_wb_reg_write", wb_reg_write, 0);
        chk("sw_after_mem_req", mem_req, 0);

        // Back-to-back LW 0x80 -> r9 then SW 0x55 -> 0x84, each acked at once.
        drive(1'b1, 32'h80, 32'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        next_edge();
        drive(1'b1, 32'h84, 32'h55, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_A5A5;
        #1;
        chk("b2b_c1_mem_req", mem_req, 1);
        chk("b2b_c1_stall", stall_o, 0);
        chk("b2b_c1_mem_addr", mem_addr, 32'h80);
        next_edge();
        idle_in();
        mem_rdata = 32'h7777_7777;
        #1;
        chk("b2b_c2_mem_req", mem_req, 1);
        chk("b2b_c2_mem_we", mem_we, 1);
        chk("b2b_c2_mem_addr", mem_addr, 32'h84);
        chk("b2b_c2_mem_wdata", mem_wdata, 32'h55);
        chk("b2b_c2_stall", stall_o, 0);
        chk("b2b_c2_wb_data", wb_data, 32'h0000_A5A5);
        chk("b2b_c2_wb_reg", wb_reg, 9);
        next_edge();
        mem_ack = 1'b0;
        #1;
        chk("b2b_c3_mem_req", mem_req, 0);
        chk("b2b_c3_wb_valid", wb_valid, 1);
        chk("b2b_c3_wb_reg_write", wb_reg_write, 0);

        // Timeout: LW 0x100 -> r4 never acknowledged.
        drive(1'b1, 32'h100, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        next_edge();
        idle_in();
        for (int c = 1; c <= TO; c++) begin
            #1;
            chk($sformatf("to_c%0d_mem_req", c), mem_req, 1);
            chk($sformatf("to_c%0d_stall", c), stall_o, (c < TO) ? 1 : 0);
            chk($sformatf("to_c%0d_bus_err", c), bus_err_o, (c == TO) ? 1 : 0);
            next_edge();
        end
        #1;
        chk("to_wb_valid", wb_valid, 1);
        chk("to_wb_reg_write", wb_reg_write, 0);
        chk("to_after_bus_err", bus_err_o, 0);
        chk("to_after_mem_req", mem_req, 0);

        // Misaligned LW 0x42 -> r0.
        drive(1'b1, 32'h42, 32'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        next_edge();
        idle_in();
        #1;
        chk("mis_pulse", misalign_o, 1);
        chk("mis_mem_addr", mem_addr, 32'h40);
        chk("mis_mem_req", mem_req, 1);
        next_edge();
        mem_ack = 1'b1;
        #1;
        chk("mis_pulse_end", misalign_o, 0);
        next_edge();
        mem_ack = 1'b0;
        chk("mis_wb_valid", wb_valid, 1);
        chk("mis_wb_reg_write", wb_reg_write, 0);

        // Reset in the middle of an access.
        drive(1'b1, 32'h200, 32'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        next_edge();
        idle_in();
        #1;
        chk("rst_mid_mem_req_before", mem_req, 1);
        reset = 1'b1;
        next_edge();
        reset = 1'b0;
        #1;
        check_reset_state("rst_mid");
        next_edge();
        chk("rst_mid_no_wb", wb_valid, 0);

        // Randomized traffic against the reference model.
        reset = 1'b1;
        idle_in();
        next_edge();
        reset   = 1'b0;
        pend    = '0;
        nxt     = '0;
        wait_c  = 0;
        lat     = 1;
        m_stall = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!m_stall) nxt = rand_instr();
            drive_instr(nxt);
            is_mem    = pend.valid && (pend.kind != 2'd0);
            ack       = is_mem && (wait_c == lat - 1);
            mem_ack   = is_mem ? ack : 1'($urandom_range(0, 1));
            mem_rdata = $urandom();
            to        = is_mem && !ack && (wait_c == TO - 1);
            #1;
            chk("rnd_stall", stall_o, is_mem && !ack && !to);
            chk("rnd_mem_req", mem_req, is_mem);
            chk("rnd_bus_err", bus_err_o, to);
            chk("rnd_fwd_en", fwd_en,
                pend.valid && pend.kind == 2'd0 && pend.rw && pend.dest != 5'd0);
            if (pend.valid && pend.kind == 2'd0 && pend.rw && pend.dest != 5'd0) begin
                chk("rnd_fwd_reg", fwd_reg, pend.dest);
                chk("rnd_fwd_value", fwd_value, pend.addr);
            end
            if (is_mem) begin
                chk("rnd_mem_we", mem_we, pend.kind == 2'd2);
                chk("rnd_mem_addr", mem_addr, {pend.addr[31:2], 2'b00});
                if (pend.kind == 2'd2) chk("rnd_mem_wdata", mem_wdata, pend.sdata);
            end

            if (is_mem && !ack && !to) begin
                e_wbv   = 1'b0;
                e_wbwe  = 1'b0;
                e_mis   = 1'b0;
                wait_c++;
                m_stall = 1'b1;
            end else begin
                e_wbv    = pend.valid;
                e_wbwe   = pend.valid && pend.rw && pend.kind != 2'd2 && pend.dest != 5'd0 && !to;
                e_wbreg  = pend.dest;
                e_wbdata = (pend.kind == 2'd1 && ack) ? mem_rdata : pend.addr;
                e_mis    = nxt.valid && nxt.kind != 2'd0 && nxt.addr[1:0] != 2'b00;
                pend     = nxt;
                wait_c   = 0;
                lat      = pick_lat();
                m_stall  = 1'b0;
            end

            next_edge();
            chk("rnd_wb_valid", wb_valid, e_wbv);
            chk("rnd_wb_reg_write", wb_reg_write, e_wbwe);
            if (e_wbv) begin
                chk("rnd_wb_reg", wb_reg, e_wbreg);
                chk("rnd_wb_data", wb_data, e_wbdata);
            end
            chk("rnd_misalign", misalign_o, e_mis);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
